// File: rtl/vbw_pkg.sv
// vbw_pkg: lane modes and carry-kill masks shared by the arbitrated adder and vbw_cla_kill.
package vbw_pkg;
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_64 = 2'b00;
    localparam mode_t MODE_32 = 2'b01;
    localparam mode_t MODE_16 = 2'b10;
    localparam mode_t MODE_8  = 2'b11;
    // A set bit k blocks the carry from bit k-1 into bit k (lane boundary).
    localparam logic [63:0] KILL_64 = 64'h0000_0000_0000_0000;
    localparam logic [63:0] KILL_32 = 64'h0000_0001_0000_0000;
    localparam logic [63:0] KILL_16 = 64'h0001_0001_0001_0000;
    localparam logic [63:0] KILL_8  = 64'h0101_0101_0101_0100;
    function automatic logic [63:0] kill_mask(mode_t m);
        return m == MODE_8 ? KILL_8 : m == MODE_16 ? KILL_16 : m == MODE_32 ? KILL_32 : KILL_64;
    endfunction
endpackage

// File: rtl/rr_arb.sv
// rr_arb: round-robin pick of the first request at or after ptr, with wrapped next pointer.
module rr_arb #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic [PW-1:0] nxt_o
);
    function automatic logic [PW-1:0] wrap(int v);
        return PW'(v % N);
    endfunction
    // Scan from the far end so the nearest request at or after ptr wins.
    always_comb begin
        gnt_o = '0;
        idx_o = ptr_i;
        nxt_o = ptr_i;
        for (int o = N - 1; o >= 0; o--) begin
            if (req_i[wrap(int'(ptr_i) + o)]) begin
                gnt_o = '0;
                gnt_o[wrap(int'(ptr_i) + o)] = 1'b1;
                idx_o = wrap(int'(ptr_i) + o);
                nxt_o = wrap(int'(ptr_i) + o + 1);
            end
        end
    end
endmodule

// File: rtl/vbw_cla_kill.sv
// vbw_cla_kill: 64-bit adder whose carry chain is cut at the lane boundaries of the selected mode.
module vbw_cla_kill
    import vbw_pkg::*;
(
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        ci_i,
    input  mode_t       mode_i,
    output logic [63:0] s_o,
    output logic        co_o
);
    logic [63:0] kill;
    logic        c;
    assign kill = kill_mask(mode_i);
    always_comb begin
        s_o = '0;
        c = ci_i & (mode_i == MODE_64);
        for (int k = 0; k < 64; k++) begin
            c = kill[k] ? 1'b0 : c;
            s_o[k] = a_i[k] ^ b_i[k] ^ c;
            c = (a_i[k] & b_i[k]) | ((a_i[k] ^ b_i[k]) & c);
        end
        co_o = c & (mode_i == MODE_64);
    end
endmodule

// File: rtl/vbw_add_arb.sv
// vbw_add_arb: round-robin arbiter sharing one variable-width 64-bit adder
// through a 2-stage registered pipeline with a tagged valid/ready response.
module vbw_add_arb
    import vbw_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [64*NREQ-1:0] req_a,
    input  logic [64*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]    req_ci,
    input  logic [2*NREQ-1:0]  req_mode,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [1:0]         rsp_mode,
    output logic [63:0]        rsp_s,
    output logic               rsp_co,
    output logic [CNTW-1:0]    op_cnt
);
    logic            s1_v_q, s1_ci_q, rsp_valid_q, rsp_co_q;
    logic [63:0]     s1_a_q, s1_b_q, rsp_s_q, sum;
    mode_t           s1_mode_q, rsp_mode_q;
    logic [IDW-1:0]  s1_id_q, rsp_id_q, ptr_q, ptr_d, gnt_id;
    logic [CNTW-1:0] cnt_q;
    logic [NREQ-1:0] gnt;
    logic            gnt_any, co, s1_adv, s2_adv;

    assign s2_adv    = !rsp_valid_q | rsp_ready;
    assign s1_adv    = !s1_v_q | s2_adv;
    assign gnt_any   = |gnt;
    assign req_ready = (s1_adv & rst_n) ? gnt : '0;

    rr_arb #(.N(NREQ), .PW(IDW)) u_arb (
        .req_i(req_valid),
        .ptr_i(ptr_q),
        .gnt_o(gnt),
        .idx_o(gnt_id),
        .nxt_o(ptr_d)
    );

    vbw_cla_kill u_add (
        .a_i(s1_a_q),
        .b_i(s1_b_q),
        .ci_i(s1_ci_q),
        .mode_i(s1_mode_q),
        .s_o(sum),
        .co_o(co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_ci_q     <= 1'b0;
            s1_mode_q   <= MODE_64;
            s1_id_q     <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_s_q     <= '0;
            rsp_co_q    <= 1'b0;
            rsp_id_q    <= '0;
            rsp_mode_q  <= MODE_64;
            cnt_q       <= '0;
        end else begin
            if (s1_adv) begin
                s1_v_q <= gnt_any;
                ptr_q  <= ptr_d;
                if (gnt_any) begin
                    s1_a_q    <= req_a[64*gnt_id +: 64];
                    s1_b_q    <= req_b[64*gnt_id +: 64];
                    s1_ci_q   <= req_ci[gnt_id];
                    s1_mode_q <= req_mode[2*gnt_id +: 2];
                    s1_id_q   <= gnt_id;
                end
            end
            if (s2_adv) begin
                rsp_valid_q <= s1_v_q;
                if (s1_v_q) begin
                    rsp_s_q    <= sum;
                    rsp_co_q   <= co;
                    rsp_id_q   <= s1_id_q;
                    rsp_mode_q <= s1_mode_q;
                end
            end
            if (rsp_valid_q & rsp_ready)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_co    = rsp_co_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_mode  = rsp_mode_q;
    assign op_cnt    = cnt_q;
endmodule

// File: tb/tb_vbw_add_arb.sv
// tb_vbw_add_arb: table vectors, grant-order streaming, stall and reset sequences,
// with a scoreboard of expected responses filled on every observed accept.
module tb_vbw_add_arb;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_ready, req_ci;
    logic [64*N-1:0] req_a, req_b;
    logic [2*N-1:0] req_mode;
    logic           rsp_valid, rsp_ready, rsp_co;
    logic [1:0]     rsp_id, rsp_mode;
    logic [63:0]    rsp_s;
    logic [31:0]    op_cnt;

    always #5 clk = ~clk;

    vbw_add_arb #(.NREQ(N), .IDW(2), .CNTW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ci(req_ci), .req_mode(req_mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_mode(rsp_mode), .rsp_s(rsp_s), .rsp_co(rsp_co),
        .op_cnt(op_cnt)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [1:0]  mode;
        logic [63:0] s;
        logic        co;
    } exp_t;

    typedef struct {
        int          id;
        logic [63:0] a;
        logic [63:0] b;
        logic        ci;
        logic [1:0]  mode;
        logic [63:0] es;
        logic        ec;
    } vec_t;

    exp_t sb[$];
    exp_t pend[N];
    int   checks = 0, errors = 0, hs_cnt = 0, exp_ptr = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Lane-by-lane reference: independent per-lane additions truncated to lane width.
    function automatic logic [64:0] model(logic [63:0] a, logic [63:0] b, logic ci, logic [1:0] m);
        logic [64:0] r;
        logic [63:0] msk;
        int w;
        if (m == 2'b00) return {1'b0, a} + {1'b0, b} + 65'(ci);
        w = 64 >> m;
        msk = (64'd1 << w) - 64'd1;
        r = '0;
        for (int l = 0; l < 64 / w; l++)
            r[63:0] = r[63:0] | (((((a >> (l * w)) & msk) + ((b >> (l * w)) & msk)) & msk) << (l * w));
        return r;
    endfunction

    task automatic set_req(int i, logic [63:0] a, logic [63:0] b, logic ci, logic [1:0] m,
                           logic [63:0] es, logic ec);
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
        req_ci[i] = ci;
        req_mode[2*i +: 2] = m;
        pend[i] = '{id: 2'(i), mode: m, s: es, co: ec};
    endtask

    task automatic rand_req(int i);
        logic [63:0] a, b;
        logic [1:0]  m;
        logic        ci;
        logic [64:0] r;
        a = {$urandom, $urandom};
        b = ($urandom_range(0, 3) == 0) ? ~a : {$urandom, $urandom};
        m = 2'($urandom_range(0, 3));
        ci = 1'($urandom_range(0, 1));
        r = model(a, b, ci, m);
        set_req(i, a, b, ci, m, r[63:0], r[64]);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++)
                if (req_ready[i]) begin
                    sb.push_back(pend[i]);
                    exp_ptr = (i + 1) % N;
                end
            if (rsp_valid && rsp_ready) begin
                chk("op_cnt", op_cnt, hs_cnt);
                hs_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp: unexpected response id %0d s %h", rsp_id, rsp_s);
                end else
                    chk("rsp", {rsp_id, rsp_mode, rsp_s, rsp_co}, sb.pop_front());
            end
        end
    end

    task automatic wait_ready(int i);
        int t;
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready[i]) break;
        end
        if (t == 20) chk("ready_timeout", 0, 1);
    endtask

    task automatic stream(int n);
        int e;
        logic [N-1:0] g;
        for (int c = 0; c < n; c++) begin
            e = exp_ptr;
            @(negedge clk);
            g = req_ready;
            chk("rr_gnt", req_ready, 128'(1 << e));
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (g[i]) rand_req(i);
        end
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 40; t++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (t == 40) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tv[8];
        logic [69:0] snap;
        tv[0] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 2'b00, 64'h0, 1'b1};
        tv[1] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 1'b1, 2'b11, 64'h0, 1'b0};
        tv[2] = '{1, 64'h0000_0001_FFFF_FFFF, 64'h1, 1'b0, 2'b01, 64'h0000_0001_0000_0000, 1'b0};
        tv[3] = '{3, 64'hFFFF_0001_8000_7FFF, 64'h0001_FFFF_8000_0001, 1'b1, 2'b10, 64'h0000_0000_0000_8000, 1'b0};
        tv[4] = '{0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 2'b00, 64'h1234_5678_9ABC_DF01, 1'b0};
        tv[5] = '{1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 2'b00, 64'h1, 1'b1};
        tv[6] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0001, 1'b1, 2'b01, 64'h0, 1'b0};
        tv[7] = '{3, 64'h7F80_FF01_0203_0405, 64'h0180_0101_0203_0405, 1'b0, 2'b11, 64'h8000_0002_0406_080A, 1'b0};

        req_valid = '1;
        req_a = '0;
        req_b = '0;
        req_ci = '0;
        req_mode = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_s", rsp_s, 0);
        chk("rst_rsp_co", rsp_co, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_mode", rsp_mode, 0);
        chk("rst_op_cnt", op_cnt, 0);
        chk("rst_req_ready", req_ready, 0);
        req_valid = '0;
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            set_req(tv[k].id, tv[k].a, tv[k].b, tv[k].ci, tv[k].mode, tv[k].es, tv[k].ec);
            req_valid[tv[k].id] = 1'b1;
            wait_ready(tv[k].id);
            @(posedge clk);
            #1;
            req_valid[tv[k].id] = 1'b0;
            @(negedge clk);
            chk("lat_s1", rsp_valid, 0);
            @(negedge clk);
            chk("lat_s2", rsp_valid, 1);
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) rand_req(i);
        req_valid = '1;
        stream(12);

        rsp_ready = 1'b0;
        snap = {rsp_valid, rsp_id, rsp_mode, rsp_s, rsp_co};
        chk("stall_snap_valid", snap[69], 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_hold", {rsp_valid, rsp_id, rsp_mode, rsp_s, rsp_co}, snap);
            chk("stall_ready", req_ready, 0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        stream(8);

        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_op_cnt", op_cnt, 0);
        sb.delete();
        hs_cnt = 0;
        exp_ptr = 0;
        set_req(0, tv[0].a, tv[0].b, tv[0].ci, tv[0].mode, tv[0].es, tv[0].ec);
        set_req(3, tv[1].a, tv[1].b, tv[1].ci, tv[1].mode, tv[1].es, tv[1].ec);
        req_valid = 4'b1001;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt0", req_ready, 4'b0001);
        chk("post_rst_no_rsp", rsp_valid, 0);
        @(posedge clk);
        #1;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("post_rst_gnt3", req_ready, 4'b1000);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();
        @(posedge clk);
        #1;
        chk("post_rst_op_cnt", op_cnt, 2);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
